// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, default unit latencies, boolean-result mask,
// reservation slot layout and latency lookup.
package fpu_pkg;

  localparam int FPU_W       = 32;
  localparam int NUM_OPS     = 21;
  localparam int CTL_W       = 5;
  localparam int TAG_W       = 4;
  localparam int FPU_MAX_LAT = 15;

  localparam int FADD    = 0;
  localparam int FSUB    = 1;
  localparam int FMUL    = 2;
  localparam int FNMUL   = 3;
  localparam int FDIV    = 4;
  localparam int FABS    = 5;
  localparam int FCVT_IF = 6;
  localparam int FCVT_FI = 7;
  localparam int FNEG    = 8;
  localparam int FEQ     = 9;
  localparam int FLT     = 10;
  localparam int FMIN    = 11;
  localparam int FMAX    = 12;
  localparam int FLE     = 13;
  localparam int FSGNJ   = 14;
  localparam int FSGNJN  = 15;
  localparam int FNE     = 16;
  localparam int FGT     = 17;
  localparam int FGE     = 18;
  localparam int SQRT    = 19;
  localparam int FSQR    = 20;

  // Op 0 sits in the least significant nibble.
  localparam logic [4*NUM_OPS-1:0] LAT_TABLE_DEF = {
    4'd2, 4'd5, {10{4'd0}}, 4'd1, 4'd2, 4'd2, 4'd0, 4'd7, 4'd3, 4'd3, 4'd4, 4'd4
  };

  // Ops 9, 10, 13, 16, 17, 18 produce a single-bit result.
  localparam logic [NUM_OPS-1:0] BOOL_MASK_DEF = 21'h072600;

  typedef struct packed {
    logic             busy;
    logic [CTL_W-1:0] ctl;
    logic [TAG_W-1:0] tag;
    logic             err;
  } resv_slot_t;

  // Illegal opcodes retire immediately, so they map to latency 0.
  function automatic logic [3:0] lat_lookup(input logic [CTL_W-1:0] ctl,
                                            input logic [4*NUM_OPS-1:0] tbl);
    if (int'(ctl) >= NUM_OPS) return 4'd0;
    return tbl[int'(ctl)*4 +: 4];
  endfunction

endpackage

// File: rtl/fpu_wb_resv.sv
// Writeback reservation shift register: one slot per future retire cycle,
// shifting toward slot 0, which is the op retiring this cycle.
module fpu_wb_resv
  import fpu_pkg::*;
#(
  parameter int DEPTH = FPU_MAX_LAT + 1,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CTL_W-1:0] wr_ctl,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_err,
  input  logic [IDX_W-1:0] q_idx,
  output logic             q_busy,
  output logic             s0_busy,
  output logic [CTL_W-1:0] s0_ctl,
  output logic [TAG_W-1:0] s0_tag,
  output logic             s0_err
);

  resv_slot_t       slot_reg  [DEPTH];
  resv_slot_t       slot_next [DEPTH];
  resv_slot_t       wr_slot;
  logic [DEPTH-1:0] busy_now;
  logic [DEPTH-1:0] busy_post;

  assign wr_slot = '{busy: 1'b1, ctl: wr_ctl, tag: wr_tag, err: wr_err};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic wr_hit;
      assign wr_hit       = wr_en && (wr_idx == IDX_W'(gi));
      assign busy_now[gi] = slot_reg[gi].busy;
      if (gi == DEPTH - 1) begin : g_top
        assign slot_next[gi] = wr_hit ? wr_slot :
                               (shift ? resv_slot_t'('0) : slot_reg[gi]);
      end else begin : g_mid
        assign slot_next[gi] = wr_hit ? wr_slot :
                               (shift ? slot_reg[gi+1] : slot_reg[gi]);
      end
    end
  endgenerate

  // Occupancy as it will look after this edge's shift, which is where a write lands.
  assign busy_post = shift ? {1'b0, busy_now[DEPTH-1:1]} : busy_now;
  assign q_busy    = busy_post[q_idx];

  assign s0_busy = slot_reg[0].busy;
  assign s0_ctl  = slot_reg[0].ctl;
  assign s0_tag  = slot_reg[0].tag;
  assign s0_err  = slot_reg[0].err;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) slot_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_reg[i] <= slot_next[i];
    end
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Pipelined FPU issue/retire sequencer: accepts one op per cycle, broadcasts
// operands to the units and retires each result on its fixed-latency cycle.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int                   W         = FPU_W,
  parameter int                   MAX_LAT   = FPU_MAX_LAT,
  parameter logic [4*NUM_OPS-1:0] LAT_TABLE = LAT_TABLE_DEF,
  parameter logic [NUM_OPS-1:0]   BOOL_MASK = BOOL_MASK_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTL_W-1:0]   in_ctl,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [W-1:0]       in_x1,
  input  logic [W-1:0]       in_x2,
  input  logic               flush,
  output logic [W-1:0]       fu_x1,
  output logic [W-1:0]       fu_x2,
  input  logic [NUM_OPS*W-1:0] fu_y,
  output logic               out_valid,
  output logic [TAG_W-1:0]   out_tag,
  output logic [W-1:0]       out_y,
  output logic               out_err,
  output logic [MAX_LAT+1:0] inflight
);

  localparam int DEPTH = MAX_LAT + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = MAX_LAT + 2;

  logic [3:0]       lat;
  logic             illegal;
  logic             q_busy;
  logic             accept;
  logic             retire;
  logic             s0_busy;
  logic [CTL_W-1:0] s0_ctl;
  logic [TAG_W-1:0] s0_tag;
  logic             s0_err;
  logic [W-1:0]     op_y [NUM_OPS];
  logic [W-1:0]     y_sel;

  assign lat      = lat_lookup(in_ctl, LAT_TABLE);
  assign illegal  = (int'(in_ctl) >= NUM_OPS);
  assign in_ready = !rst && !flush && !q_busy;
  assign accept   = in_valid && in_ready;
  assign retire   = s0_busy && !flush;

  fpu_wb_resv #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_resv (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .shift   (1'b1),
    .wr_en   (accept),
    .wr_idx  (IDX_W'(lat)),
    .wr_ctl  (in_ctl),
    .wr_tag  (in_tag),
    .wr_err  (illegal),
    .q_idx   (IDX_W'(lat)),
    .q_busy  (q_busy),
    .s0_busy (s0_busy),
    .s0_ctl  (s0_ctl),
    .s0_tag  (s0_tag),
    .s0_err  (s0_err)
  );

  // Boolean-result units only drive a meaningful bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_y
      assign op_y[gi] = BOOL_MASK[gi] ? {{(W-1){1'b0}}, fu_y[gi*W]} : fu_y[gi*W +: W];
    end
  endgenerate

  always_comb begin
    y_sel = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (!s0_err && int'(s0_ctl) == i) y_sel = op_y[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fu_x1     <= '0;
      fu_x2     <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_y     <= '0;
      out_err   <= 1'b0;
      inflight  <= '0;
    end else begin
      if (accept) begin
        fu_x1 <= in_x1;
        fu_x2 <= in_x2;
      end
      out_valid <= retire;
      if (retire) begin
        out_tag <= s0_tag;
        out_err <= s0_err;
        out_y   <= y_sel;
      end
      if (flush) inflight <= '0;
      else       inflight <= inflight + CNT_W'(accept) - CNT_W'(retire);
    end
  end

endmodule
